clk_gen_ctrl: RTL and testbench
===============================

# clk_gen_ctrl

Synthesizable controller that sequences a programmable clock-enable waveform for the test clock generators. It holds an active configuration (period, high time, start phase in `clk` cycles), accepts new configurations through a valid/ready handshake, and applies them only on period boundaries so `clk_out` never glitches. It starts and stops the waveform cleanly on `enable` and sits between the bench/register interface and any block consuming the generated clock or strobe.

## Interface
- `CNT_W`, 16: width of all count fields and internal counters.
- `DEF_PERIOD`, 4: active period after reset, in `clk` cycles.
- `DEF_HIGH`, 2: active high time after reset.
- `DEF_PHASE`, 0: active start delay after reset.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: run request, level-sensitive.
- `cfg_valid` input 1: new configuration offered.
- `cfg_ready` output 1: pending slot empty; reset 1.
- `cfg_period` input CNT_W: period in cycles.
- `cfg_high` input CNT_W: high cycles per period.
- `cfg_phase` input CNT_W: delay from start to first high.
- `cfg_err` output 1: one-cycle pulse, offered config rejected; reset 0.
- `clk_out` output 1: generated waveform, registered; reset 0.
- `running` output 1: state is not IDLE; reset 0.
- `period_tick` output 1: one-cycle pulse on the last cycle of each LOW phase; reset 0.

## Operation
- States: IDLE, PHASE, HIGH, LOW. Reset goes to IDLE, loads the DEF_* values as active, empties the pending slot, and zeroes all counters.
- Validity: `cfg_period >= 2`, `1 <= cfg_high <= cfg_period-1`, `cfg_phase < cfg_period`.
- On `cfg_valid && cfg_ready`:
  - Valid config: it is stored in the pending slot and `cfg_ready` drops on the next edge.
  - Invalid config: `cfg_err` pulses on the next edge, nothing is stored, and `cfg_ready` stays 1.
- Applying pending to active:
  - In IDLE, it is applied on the edge after acceptance.
  - While running, it is applied only on the LOW→HIGH boundary edge.
  - `cfg_ready` returns to 1 on the same edge that the config is applied.
- State transitions:
  - IDLE→PHASE if `enable` is sampled high and phase > 0. IDLE→HIGH if `enable` is sampled high and phase = 0.
  - PHASE lasts phase cycles, then goes to HIGH.
  - HIGH lasts high cycles, then goes to LOW.
  - LOW lasts period−high cycles. On its last cycle `period_tick` = 1. Next state is HIGH if `enable` = 1, else IDLE.
- Phase delay is inserted only on a start from IDLE, never between periods.
- `enable` deasserted mid-period: the current period completes and the block stops at the LOW boundary.
  - Re-asserting `enable` before that boundary continues without interruption.
  - Deasserting `enable` in PHASE returns to IDLE immediately with `clk_out` = 0.
- `clk_out` = 1 exactly in HIGH and 0 otherwise. It is registered in the same cycle as the state.
- Counters are CNT_W bits, count down from value−1 to 0, and never wrap because validity bounds them.

## Timing
- Start latency: `enable` high at edge t with phase 0 → `clk_out` = 1 from edge t.
- With phase p, `clk_out` = 1 from edge t+p.
- Steady state: `clk_out` high for exactly high cycles and low for exactly period−high cycles.
- Reconfiguration never produces a partial high or low segment.
- Simultaneous accept and boundary:
  - The config accepted on the boundary edge itself is not applied until the next boundary.
  - A config already pending is applied at the boundary regardless.
- Async reset mid-operation: `clk_out`, `running`, `period_tick` and `cfg_err` go to 0 immediately and `cfg_ready` goes to 1. The pending config is discarded.

## Configuration
- `CLK_GEN_CTRL_PERIOD_CNT_EN` defined:
  - Adds output `period_cnt` [31:0], which increments on every `period_tick` and wraps at 2^32−1 → 0.
  - It clears to 0 on reset only.
- `CLK_GEN_CTRL_PERIOD_CNT_EN` not defined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Package `clk_gen_ctrl_pkg` holds:
  - the state enum `clk_gen_state_e` (IDLE, PHASE, HIGH, LOW);
  - the config struct `clk_gen_cfg_t` (period, high, phase);
  - the default constants.
- Sub-module `clk_gen_ctrl_cfg` holds the validity check, pending slot, `cfg_ready`/`cfg_err` generation, and the apply strobe input.
- The top level holds the FSM, the counters, and the output registers.

## Test plan
- Reset defaults, `enable` = 1: `clk_out` repeats 1,1,0,0 and `period_tick` asserts on every 4th cycle.
- Config period 5, high 1, phase 3 in IDLE, then `enable`: three cycles low, then pattern 1,0,0,0,0. `cfg_ready` is 0 for exactly one cycle.
- Mid-run config period 6, high 3, offered during HIGH:
  - The old waveform completes its period.
  - The new 3/3 pattern starts at the boundary.
  - `cfg_ready` stays 0 until that boundary edge.
- Invalid configs are rejected with `cfg_err` = 1 for one cycle and no waveform change:
  - period 1;
  - high 0;
  - high = period;
  - phase 8 with period 8.
- `enable` dropped in the first HIGH cycle: the full period finishes, `clk_out` stays 0, and `running` = 0 after the LOW boundary. Dropping `enable` in PHASE returns to IDLE on the next edge.
- `rst_n` pulsed low mid-HIGH: `clk_out` = 0 asynchronously and the pending config is lost. With `CLK_GEN_CTRL_PERIOD_CNT_EN` defined, `period_cnt` = 0.

Source files
------------

// File: rtl/clk_gen_ctrl_pkg.sv
// Shared types, default configuration and the config validity rule for clk_gen_ctrl.
// Optional feature macro used by the top: CLK_GEN_CTRL_PERIOD_CNT_EN.
package clk_gen_ctrl_pkg;

  localparam int unsigned CFG_CNT_W          = 16;
  localparam int unsigned CLK_GEN_DEF_PERIOD = 4;
  localparam int unsigned CLK_GEN_DEF_HIGH   = 2;
  localparam int unsigned CLK_GEN_DEF_PHASE  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } clk_gen_state_e;

  typedef struct packed {
    logic [CFG_CNT_W-1:0] period;
    logic [CFG_CNT_W-1:0] high;
    logic [CFG_CNT_W-1:0] phase;
  } clk_gen_cfg_t;

  // A config must leave at least one high and one low cycle per period.
  function automatic logic cfg_is_valid(input clk_gen_cfg_t c);
    return (c.period >= CFG_CNT_W'(2)) &&
           (c.high != '0) &&
           (c.high < c.period) &&
           (c.phase < c.period);
  endfunction

endpackage

// File: rtl/clk_gen_ctrl_cfg.sv
// Config intake: validity check, single-entry pending slot, cfg_ready/cfg_err generation.
// The pending slot is released by the apply strobe from the sequencer.
module clk_gen_ctrl_cfg
  import clk_gen_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CFG_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic             apply,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             pend_valid,
  output logic [CNT_W-1:0] pend_period,
  output logic [CNT_W-1:0] pend_high,
  output logic [CNT_W-1:0] pend_phase
);

  clk_gen_cfg_t pend_q, pend_d;
  clk_gen_cfg_t offer_c;
  logic         pend_valid_q, pend_valid_d;
  logic         cfg_ready_q, cfg_ready_d;
  logic         cfg_err_q, cfg_err_d;
  logic         accept_c;

  always_comb begin
    offer_c.period = CFG_CNT_W'(cfg_period);
    offer_c.high   = CFG_CNT_W'(cfg_high);
    offer_c.phase  = CFG_CNT_W'(cfg_phase);
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    cfg_err_d      = 1'b0;
    accept_c       = cfg_valid && cfg_ready_q;

    // Apply and accept are exclusive: apply needs a full slot, accept an empty one.
    if (apply) begin
      pend_valid_d = 1'b0;
    end
    if (accept_c) begin
      if (cfg_is_valid(offer_c)) begin
        pend_d       = offer_c;
        pend_valid_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    cfg_ready_d = !pend_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      cfg_ready_q  <= 1'b1;
      cfg_err_q    <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign cfg_err     = cfg_err_q;
  assign pend_valid  = pend_valid_q;
  assign pend_period = CNT_W'(pend_q.period);
  assign pend_high   = CNT_W'(pend_q.high);
  assign pend_phase  = CNT_W'(pend_q.phase);

endmodule

// File: rtl/clk_gen_ctrl.sv
// Glitch-free programmable clock-enable sequencer; configs take effect only on period boundaries.
// Define CLK_GEN_CTRL_PERIOD_CNT_EN to add the 32-bit period_cnt output.
module clk_gen_ctrl
  import clk_gen_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = CFG_CNT_W,
  parameter int unsigned DEF_PERIOD = CLK_GEN_DEF_PERIOD,
  parameter int unsigned DEF_HIGH   = CLK_GEN_DEF_HIGH,
  parameter int unsigned DEF_PHASE  = CLK_GEN_DEF_PHASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             running,
  output logic             period_tick
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  clk_gen_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic [CNT_W-1:0] act_phase_q, act_phase_d;
  logic             clk_out_q, clk_out_d;
  logic             running_q, running_d;
  logic             period_tick_q, period_tick_d;

  logic             pend_valid;
  logic [CNT_W-1:0] pend_period, pend_high, pend_phase;
  logic             apply_c;
  logic [CNT_W-1:0] eff_period, eff_high, eff_phase;

  clk_gen_ctrl_cfg #(
    .CNT_W (CNT_W)
  ) u_cfg (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_phase   (cfg_phase),
    .apply       (apply_c),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .pend_valid  (pend_valid),
    .pend_period (pend_period),
    .pend_high   (pend_high),
    .pend_phase  (pend_phase)
  );

  always_comb begin
    // Pending config is taken while idle or on the LOW->HIGH boundary edge only.
    apply_c = pend_valid &&
              ((state_q == IDLE) ||
               ((state_q == LOW) && (cnt_q == '0) && enable));
    eff_period = apply_c ? pend_period : act_period_q;
    eff_high   = apply_c ? pend_high   : act_high_q;
    eff_phase  = apply_c ? pend_phase  : act_phase_q;

    state_d      = state_q;
    cnt_d        = cnt_q;
    act_period_d = eff_period;
    act_high_d   = eff_high;
    act_phase_d  = eff_phase;

    case (state_q)
      IDLE: begin
        if (enable) begin
          if (eff_phase != '0) begin
            state_d = PHASE;
            cnt_d   = eff_phase - CNT_W'(1);
          end else begin
            state_d = HIGH;
            cnt_d   = eff_high - CNT_W'(1);
          end
        end
      end
      PHASE: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = eff_high - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = eff_period - eff_high - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          if (enable) begin
            state_d = HIGH;
            cnt_d   = eff_high - CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    clk_out_d     = (state_d == HIGH);
    running_d     = (state_d != IDLE);
    period_tick_d = (state_d == LOW) && (cnt_d == '0);
  end

`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
  logic [31:0] period_cnt_q, period_cnt_d;

  always_comb begin
    period_cnt_d = period_tick_q ? (period_cnt_q + 32'd1) : period_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q <= '0;
    end else begin
      period_cnt_q <= period_cnt_d;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      act_period_q  <= CNT_W'(DEF_PERIOD);
      act_high_q    <= CNT_W'(DEF_HIGH);
      act_phase_q   <= CNT_W'(DEF_PHASE);
      clk_out_q     <= 1'b0;
      running_q     <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
      act_phase_q   <= act_phase_d;
      clk_out_q     <= clk_out_d;
      running_q     <= running_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign running     = running_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed self-checking bench for clk_gen_ctrl; expected waveforms are hand-derived per cycle.
// Also covers the optional period_cnt output when CLK_GEN_CTRL_PERIOD_CNT_EN is defined.
module tb_clk_gen_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [15:0] cfg_high;
  logic [15:0] cfg_phase;
  logic        cfg_err;
  logic        clk_out;
  logic        running;
  logic        period_tick;
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
  logic [31:0] period_cnt;
`endif

  int n_total;
  int n_bad;

  clk_gen_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_phase   (cfg_phase),
    .cfg_err     (cfg_err),
    .clk_out     (clk_out),
    .running     (running),
    .period_tick (period_tick)
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt  (period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int unsigned p, input int unsigned h, input int unsigned ph);
    cfg_valid  = 1'b1;
    cfg_period = 16'(p);
    cfg_high   = 16'(h);
    cfg_phase  = 16'(ph);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int unsigned inv_p[4];
    int unsigned inv_h[4];
    int unsigned inv_ph[4];
    inv_p  = '{1, 4, 4, 8};
    inv_h  = '{1, 0, 4, 1};
    inv_ph = '{0, 0, 0, 8};
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_phase  = '0;

    #12;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_err", 32'(cfg_err), 32'd0);

    // Default 4/2/0 waveform.
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("dflt_clk", 32'(clk_out), 32'((i % 4) < 2));
      check("dflt_tick", 32'(period_tick), 32'((i % 4) == 3));
      check("dflt_running", 32'(running), 32'd1);
    end
    enable = 1'b0;
    tick();
    check("dflt_stop_running", 32'(running), 32'd0);
    check("dflt_stop_clk", 32'(clk_out), 32'd0);
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
    check("period_cnt_3", period_cnt, 32'd3);
`endif

    // 5/1/3 loaded while idle.
    offer(5, 1, 3);
    tick();
    check("idle_acc_ready", 32'(cfg_ready), 32'd0);
    check("idle_acc_err", 32'(cfg_err), 32'd0);
    cfg_valid = 1'b0;
    tick();
    check("idle_apply_ready", 32'(cfg_ready), 32'd1);
    check("idle_apply_running", 32'(running), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("p513_clk", 32'(clk_out), 32'((i >= 3) && (((i - 3) % 5) == 0)));
      check("p513_tick", 32'(period_tick), 32'((i >= 3) && (((i - 3) % 5) == 4)));
      check("p513_running", 32'(running), 32'd1);
    end

    // Mid-run 6/3/0 offered in the single HIGH cycle.
    tick();
    check("mid_high", 32'(clk_out), 32'd1);
    offer(6, 3, 0);
    tick();
    cfg_valid = 1'b0;
    check("mid_acc_clk", 32'(clk_out), 32'd0);
    check("mid_acc_ready", 32'(cfg_ready), 32'd0);
    check("mid_acc_tick", 32'(period_tick), 32'd0);
    for (int j = 1; j < 4; j++) begin
      tick();
      check("mid_old_clk", 32'(clk_out), 32'd0);
      check("mid_old_ready", 32'(cfg_ready), 32'd0);
      check("mid_old_tick", 32'(period_tick), 32'(j == 3));
    end
    for (k = 0; k < 12; k++) begin
      tick();
      check("p63_clk", 32'(clk_out), 32'((k % 6) < 3));
      check("p63_tick", 32'(period_tick), 32'((k % 6) == 5));
      if (k == 0) check("p63_ready", 32'(cfg_ready), 32'd1);
    end

    // Invalid configs while running: error pulse, waveform untouched.
    for (int v = 0; v < 4; v++) begin
      offer(inv_p[v], inv_h[v], inv_ph[v]);
      tick();
      check("inv_err", 32'(cfg_err), 32'd1);
      check("inv_ready", 32'(cfg_ready), 32'd1);
      check("inv_clk", 32'(clk_out), 32'((k % 6) < 3));
      k++;
      cfg_valid = 1'b0;
      tick();
      check("inv_err_clr", 32'(cfg_err), 32'd0);
      check("inv_clk", 32'(clk_out), 32'((k % 6) < 3));
      k++;
    end

    // Drop enable in the first HIGH cycle: period completes then stop.
    for (; k <= 24; k++) begin
      tick();
      check("pre_drop_clk", 32'(clk_out), 32'((k % 6) < 3));
    end
    enable = 1'b0;
    for (; k <= 29; k++) begin
      tick();
      check("drop_clk", 32'(clk_out), 32'((k % 6) < 3));
      check("drop_running", 32'(running), 32'd1);
      check("drop_tick", 32'(period_tick), 32'(k == 29));
    end
    tick();
    check("drop_idle_running", 32'(running), 32'd0);
    check("drop_idle_clk", 32'(clk_out), 32'd0);
    tick();
    check("drop_idle_clk2", 32'(clk_out), 32'd0);

    // Drop enable during PHASE.
    offer(6, 3, 2);
    tick();
    check("ph_acc_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    tick();
    check("ph_apply_ready", 32'(cfg_ready), 32'd1);
    enable = 1'b1;
    tick();
    check("ph_running", 32'(running), 32'd1);
    check("ph_clk", 32'(clk_out), 32'd0);
    enable = 1'b0;
    tick();
    check("ph_abort_running", 32'(running), 32'd0);
    check("ph_abort_clk", 32'(clk_out), 32'd0);

    // Async reset mid-HIGH with a config pending.
    enable = 1'b1;
    tick();
    tick();
    check("rh_phase_clk", 32'(clk_out), 32'd0);
    tick();
    check("rh_high_clk", 32'(clk_out), 32'd1);
    offer(8, 4, 0);
    tick();
    cfg_valid = 1'b0;
    check("rh_pend_ready", 32'(cfg_ready), 32'd0);
    check("rh_pend_clk", 32'(clk_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clk", 32'(clk_out), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    check("arst_tick", 32'(period_tick), 32'd0);
    check("arst_err", 32'(cfg_err), 32'd0);
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
    check("arst_period_cnt", period_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_clk", 32'(clk_out), 32'((i % 4) < 2));
      check("post_rst_tick", 32'(period_tick), 32'((i % 4) == 3));
      if (i == 0) check("post_rst_ready", 32'(cfg_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
